// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite subordinate backed by a single-port word array.
// Handshake rule: a transfer happens on a rising edge where valid && ready;
// valids come only from registered state, and readies come only from state,
// so neither depends combinationally on the opposite channel's signal.
// A write commit owns the array port for one cycle and holds off AR then.
module axi_lite_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 'h1000,
  parameter int                    MEM_WORDS  = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  output logic [1:0]              s_bresp_o,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic                    dbg_r_state_o,
  output logic [1:0]              dbg_w_state_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

  r_state_t r_state, r_state_nx;
  w_state_t w_state, w_state_nx;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  aw_got;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  w_got;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, w_hs, ar_hs, write_commit;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // True when the byte address falls inside the backed window.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - MEM_BASE) >> LSB;
    return (a >= MEM_BASE) && (off < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  // Word index of an in-window address; byte-offset bits are dropped.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - MEM_BASE) >> LSB;
    return off[IDX_W-1:0];
  endfunction

  assign write_commit = (w_state == W_COMMIT);
  assign s_awready_o  = (w_state == W_IDLE) && !aw_got;
  assign s_wready_o   = (w_state == W_IDLE) && !w_got;
  assign s_arready_o  = (r_state == R_IDLE) && !write_commit;
  assign s_bvalid_o   = (w_state == W_RESP);
  assign s_rvalid_o   = (r_state == R_RESP);
  assign s_bresp_o    = bresp_q;
  assign s_rresp_o    = rresp_q;
  assign s_rdata_o    = rdata_q;

  assign aw_hs = s_awvalid_i && s_awready_o;
  assign w_hs  = s_wvalid_i && s_wready_o;
  assign ar_hs = s_arvalid_i && s_arready_o;

  assign dbg_r_state_o = r_state;
  assign dbg_w_state_o = w_state;

  // Read next-state: one response outstanding at a time.
  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_RESP;
      R_RESP:  if (s_rready_i) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read state, captured read data and response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_state_nx;
      if (ar_hs) begin
        if (in_window(s_araddr_i)) begin
          rdata_q <= mem[word_idx(s_araddr_i)];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // Write next-state: commit once both address and data are held.
  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) w_state_nx = W_COMMIT;
      W_COMMIT: w_state_nx = W_RESP;
      W_RESP:   if (s_bready_i) w_state_nx = W_IDLE;
      default:  w_state_nx = W_IDLE;
    endcase
  end

  // Write state, independent AW/W capture and write response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      aw_got    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_got     <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_state_nx;
      if (aw_hs) begin
        aw_addr_q <= s_awaddr_i;
        aw_got    <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= s_wdata_i;
        wstrb_q <= s_wstrb_i;
        w_got   <= 1'b1;
      end
      if (write_commit) begin
        bresp_q <= in_window(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      end
      if ((w_state == W_RESP) && s_bready_i) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // Array write port: byte lanes during the commit cycle; contents never reset.
  always_ff @(posedge clk_i) begin
    if (write_commit && in_window(aw_addr_q)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder (32-bit data, 128 words at 0x1000).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
module tb_axi_lite_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] s_awaddr_i;
  logic        s_awvalid_i;
  logic        s_awready_o;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic        s_wvalid_i;
  logic        s_wready_o;
  logic [1:0]  s_bresp_o;
  logic        s_bvalid_o;
  logic        s_bready_i;
  logic [31:0] s_araddr_i;
  logic        s_arvalid_i;
  logic        s_arready_o;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rvalid_o;
  logic        s_rready_i;
  logic        dbg_r_state_o;
  logic [1:0]  dbg_w_state_o;

  axi_lite_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .dbg_r_state_o(dbg_r_state_o), .dbg_w_state_o(dbg_w_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [31:0] model [128];

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1200);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h1000) / 4);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_win(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_win(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (in_win(a)) begin
      w = model[widx(a)];
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[widx(a)] = w;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    s_awaddr_i = '0; s_awvalid_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b0; s_araddr_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
  endtask

  // AW and W presented together; returns BRESP (x on timeout).
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_done, w_done, got;
    resp = 2'bxx; aw_done = 0; w_done = 0; got = 0;
    s_awaddr_i = a; s_awvalid_i = 1'b1; s_wdata_i = d; s_wstrb_i = s; s_wvalid_i = 1'b1;
    for (int g = 0; g < 20 && !(aw_done && w_done); g++) begin
      @(negedge clk_i);
      if (s_awvalid_i && s_awready_o) aw_done = 1;
      if (s_wvalid_i && s_wready_o) w_done = 1;
      @(posedge clk_i); #1;
      if (aw_done) s_awvalid_i = 1'b0;
      if (w_done) s_wvalid_i = 1'b0;
    end
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b1;
    for (int g = 0; g < 20 && !got; g++) begin
      @(negedge clk_i);
      if (s_bvalid_o) begin resp = s_bresp_o; got = 1; end
      @(posedge clk_i); #1;
    end
    s_bready_i = 1'b0;
  endtask

  // Returns data/resp and the number of falling edges from AR handshake to
  // RVALID (-1 on timeout).
  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    bit hs;
    hs = 0; lat = -1; data = 'x; resp = 2'bxx;
    s_araddr_i = a; s_arvalid_i = 1'b1;
    for (int g = 0; g < 20 && !hs; g++) begin
      @(negedge clk_i);
      if (s_arready_o) hs = 1;
      @(posedge clk_i); #1;
    end
    s_arvalid_i = 1'b0;
    if (hs) begin
      s_rready_i = 1'b1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(negedge clk_i);
        if (s_rvalid_o) begin data = s_rdata_o; resp = s_rresp_o; lat = k; end
        @(posedge clk_i); #1;
      end
      s_rready_i = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    #12;
    n_cmp++; if (s_awready_o !== 1'b1) begin n_fail++; $display("FAIL reset_awready got %b need 1", s_awready_o); end
    n_cmp++; if (s_wready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b need 1", s_wready_o); end
    n_cmp++; if (s_arready_o !== 1'b1) begin n_fail++; $display("FAIL reset_arready got %b need 1", s_arready_o); end
    n_cmp++; if (s_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got %b need 0", s_bvalid_o); end
    n_cmp++; if (s_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b need 0", s_rvalid_o); end
    n_cmp++; if (s_bresp_o !== 2'b00) begin n_fail++; $display("FAIL reset_bresp got %b need 00", s_bresp_o); end
    n_cmp++; if (s_rresp_o !== 2'b00) begin n_fail++; $display("FAIL reset_rresp got %b need 00", s_rresp_o); end
    n_cmp++; if (s_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h need 0", s_rdata_o); end
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_fill_and_read();
    logic [1:0] r; logic [31:0] d; int lat; logic [31:0] a;
    for (int i = 0; i < 128; i++) begin
      a = 32'h1000 + 32'(4*i);
      do_write(a, a, 4'hF, r);
      model_write(a, a, 4'hF);
      n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL fill_bresp addr %h got %b need 00", a, r); end
    end
    for (a = 32'h1000; a <= 32'h11C0; a += 4) begin
      do_read(a, d, r, lat);
      n_cmp++; if (d !== a) begin n_fail++; $display("FAIL fill_rdata addr %h got %h need %h", a, d, a); end
      n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL fill_rresp addr %h got %b need 00", a, r); end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL read_latency addr %h got %0d need 1", a, lat); end
    end
  endtask

  task automatic test_write_order();
    int first_b; logic [1:0] bseen; bit whs, awhs; logic wr_at1;
    logic [31:0] d; logic [1:0] r; int lat;
    first_b = -1; bseen = 2'bxx; wr_at1 = 1'bx;
    s_awaddr_i = 32'h1004; s_wdata_i = 32'hDEADBEEF; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) s_awvalid_i = 1'b1;
      @(negedge clk_i);
      whs = s_wvalid_i && s_wready_o;
      awhs = s_awvalid_i && s_awready_o;
      if (c == 1) wr_at1 = s_wready_o;
      if (s_bvalid_o && first_b < 0) begin first_b = c; bseen = s_bresp_o; end
      @(posedge clk_i); #1;
      if (whs) s_wvalid_i = 1'b0;
      if (awhs) s_awvalid_i = 1'b0;
    end
    n_cmp++; if (wr_at1 !== 1'b0) begin n_fail++; $display("FAIL order_wready_held got %b need 0", wr_at1); end
    n_cmp++; if (first_b !== 5) begin n_fail++; $display("FAIL order_bvalid_cycle got %0d need 5", first_b); end
    n_cmp++; if (bseen !== 2'b00) begin n_fail++; $display("FAIL order_bresp got %b need 00", bseen); end
    s_bready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (s_bvalid_o !== 1'b1) begin n_fail++; $display("FAIL order_bvalid_hold got %b need 1", s_bvalid_o); end
    @(posedge clk_i); #1; s_bready_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (s_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL order_bvalid_drop got %b need 0", s_bvalid_o); end
    @(posedge clk_i); #1;
    model_write(32'h1004, 32'hDEADBEEF, 4'hF);
    do_read(32'h1004, d, r, lat);
    n_cmp++; if (d !== exp_rdata(32'h1004)) begin n_fail++; $display("FAIL order_readback got %h need %h", d, exp_rdata(32'h1004)); end
  endtask

  task automatic test_strobes();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h1008, 32'hFFFFFFFF, 4'hF, r);   model_write(32'h1008, 32'hFFFFFFFF, 4'hF);
    do_write(32'h1008, 32'h11223344, 4'b0101, r); model_write(32'h1008, 32'h11223344, 4'b0101);
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL strobe_bresp got %b need 00", r); end
    do_read(32'h1008, d, r, lat);
    n_cmp++; if (d !== exp_rdata(32'h1008)) begin n_fail++; $display("FAIL strobe_rdata got %h need %h", d, exp_rdata(32'h1008)); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [4]; logic [1:0] r; logic [31:0] d, a, wd; int lat;
    addrs[0] = 32'h2000; addrs[1] = 32'h1200; addrs[2] = 32'h0FFC; addrs[3] = 32'h11FF;
    for (int i = 0; i < 4; i++) begin
      a = addrs[i]; wd = $urandom;
      do_write(a, wd, 4'hF, r); model_write(a, wd, 4'hF);
      n_cmp++; if (r !== exp_resp(a)) begin n_fail++; $display("FAIL oob_bresp addr %h got %b need %b", a, r, exp_resp(a)); end
      do_read(a, d, r, lat);
      n_cmp++; if (r !== exp_resp(a)) begin n_fail++; $display("FAIL oob_rresp addr %h got %b need %b", a, r, exp_resp(a)); end
      n_cmp++; if (d !== exp_rdata(a)) begin n_fail++; $display("FAIL oob_rdata addr %h got %h need %h", a, d, exp_rdata(a)); end
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'h1000 + 4 * $urandom_range(0, 127);
      do_read(a, d, r, lat);
      n_cmp++; if (d !== exp_rdata(a)) begin n_fail++; $display("FAIL oob_untouched addr %h got %h need %h", a, d, exp_rdata(a)); end
    end
  endtask

  task automatic test_collision();
    bit hs; logic [31:0] d; logic [1:0] r; int got;
    hs = 0; got = 0; d = 'x; r = 2'bxx;
    s_awaddr_i = 32'h100C; s_awvalid_i = 1'b1; s_wdata_i = 32'h5; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    s_bready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if ({s_awready_o, s_wready_o} !== 2'b11) begin n_fail++; $display("FAIL coll_accept got %b need 11", {s_awready_o, s_wready_o}); end
    @(posedge clk_i); #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    model_write(32'h100C, 32'h5, 4'hF);
    s_araddr_i = 32'h100C; s_arvalid_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (s_arready_o !== 1'b0) begin n_fail++; $display("FAIL coll_arready got %b need 0", s_arready_o); end
    @(posedge clk_i); #1;
    for (int g = 0; g < 10 && !hs; g++) begin
      @(negedge clk_i);
      if (s_arready_o) hs = 1;
      @(posedge clk_i); #1;
    end
    s_arvalid_i = 1'b0; s_bready_i = 1'b0; s_rready_i = 1'b1;
    for (int g = 0; g < 10 && got == 0; g++) begin
      @(negedge clk_i);
      if (s_rvalid_o) begin d = s_rdata_o; r = s_rresp_o; got = 1; end
      @(posedge clk_i); #1;
    end
    s_rready_i = 1'b0;
    n_cmp++; if (d !== exp_rdata(32'h100C)) begin n_fail++; $display("FAIL coll_rdata got %h need %h", d, exp_rdata(32'h100C)); end
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL coll_rresp got %b need 00", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, a2, exp, wd, d; logic [1:0] r; bit hs; int lat;
    a = 32'h1000 + 4 * $urandom_range(0, 127);
    a2 = 32'h1000 + 4 * $urandom_range(0, 127);
    exp = exp_rdata(a);
    hs = 0;
    s_araddr_i = a; s_arvalid_i = 1'b1;
    for (int g = 0; g < 10 && !hs; g++) begin
      @(negedge clk_i); if (s_arready_o) hs = 1;
      @(posedge clk_i); #1;
    end
    s_araddr_i = a2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({s_rvalid_o, s_arready_o, s_rresp_o, s_rdata_o} !== {1'b1, 1'b0, 2'b00, exp}) begin
        n_fail++;
        $display("FAIL r_backpressure cycle %0d got v=%b ar=%b resp=%b data=%h need v=1 ar=0 resp=00 data=%h",
                 c, s_rvalid_o, s_arready_o, s_rresp_o, s_rdata_o, exp);
      end
      @(posedge clk_i); #1;
    end
    s_arvalid_i = 1'b0; s_rready_i = 1'b1;
    @(posedge clk_i); #1; s_rready_i = 1'b0;
    do_read(a2, d, r, lat);
    n_cmp++; if (d !== exp_rdata(a2)) begin n_fail++; $display("FAIL r_after_bp addr %h got %h need %h", a2, d, exp_rdata(a2)); end
    // Write response held under backpressure.
    a = 32'h1000 + 4 * $urandom_range(0, 127); wd = $urandom;
    s_awaddr_i = a; s_awvalid_i = 1'b1; s_wdata_i = wd; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    @(posedge clk_i); #1; s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    model_write(a, wd, 4'hF);
    @(posedge clk_i); #1;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({s_bvalid_o, s_awready_o, s_wready_o, s_bresp_o} !== 5'b10000) begin
        n_fail++;
        $display("FAIL b_backpressure cycle %0d got bv=%b aw=%b w=%b resp=%b need bv=1 aw=0 w=0 resp=00",
                 c, s_bvalid_o, s_awready_o, s_wready_o, s_bresp_o);
      end
      @(posedge clk_i); #1;
    end
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_bready_i = 1'b1;
    @(posedge clk_i); #1; s_bready_i = 1'b0;
    do_read(a, d, r, lat);
    n_cmp++; if (d !== exp_rdata(a)) begin n_fail++; $display("FAIL b_after_bp addr %h got %h need %h", a, d, exp_rdata(a)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, d; logic [1:0] r; int lat;
    a = 32'h1000 + 4 * $urandom_range(0, 127);
    b = 32'h1000 + 4 * $urandom_range(0, 127);
    s_awaddr_i = a; s_awvalid_i = 1'b1; s_wdata_i = ~model[widx(a)]; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    s_araddr_i = b; s_arvalid_i = 1'b1;
    @(posedge clk_i); #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_arvalid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (s_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid_before got %b need 1", s_rvalid_o); end
    #2 rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({s_rvalid_o, s_bvalid_o, s_awready_o, s_wready_o, s_arready_o} !== 5'b00111) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got rv=%b bv=%b aw=%b w=%b ar=%b need 0 0 1 1 1",
               s_rvalid_o, s_bvalid_o, s_awready_o, s_wready_o, s_arready_o);
    end
    @(posedge clk_i); @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    do_read(a, d, r, lat);
    n_cmp++; if (d !== exp_rdata(a)) begin n_fail++; $display("FAIL mid_no_write addr %h got %h need %h", a, d, exp_rdata(a)); end
    for (int i = 0; i < 8; i++) begin
      b = 32'h1000 + 4 * $urandom_range(0, 127);
      do_read(b, d, r, lat);
      n_cmp++; if (d !== exp_rdata(b)) begin n_fail++; $display("FAIL mid_survive addr %h got %h need %h", b, d, exp_rdata(b)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, d; logic [3:0] s; logic [1:0] r; int lat;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) a = 32'h1000 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 1) a = 32'h1200 + 4 * $urandom_range(0, 1000);
      else a = 4 * $urandom_range(0, 1023);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, wd, s, r); model_write(a, wd, s);
        n_cmp++; if (r !== exp_resp(a)) begin n_fail++; $display("FAIL rand_bresp addr %h got %b need %b", a, r, exp_resp(a)); end
      end else begin
        do_read(a, d, r, lat);
        n_cmp++;
        if ({d, r} !== {exp_rdata(a), exp_resp(a)}) begin
          n_fail++;
          $display("FAIL rand_read addr %h got %h/%b need %h/%b", a, d, r, exp_rdata(a), exp_resp(a));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_and_read();
    test_write_order();
    test_strobes();
    test_out_of_range();
    test_collision();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
